// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full/level logic of an asynchronous FIFO.
// Holds the binary write counter and its Gray copy. Derives full, almost-full, level and overflow from the synchronized read pointer.
module fifo_wptr_full #(
   parameter int ADDR_WIDTH   = 3,
   parameter int AFULL_THRESH = 2**ADDR_WIDTH - 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  winc,
   input  logic [ADDR_WIDTH:0]   wq2_rptr,
   output logic [ADDR_WIDTH:0]   wptr,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic                  wen,
   output logic                  wfull,
   output logic                  walmost_full,
   output logic [ADDR_WIDTH:0]   wlevel,
   output logic                  woverflow
);

   localparam logic [ADDR_WIDTH:0] AFULL_LVL = (ADDR_WIDTH+1)'(AFULL_THRESH);

   logic [ADDR_WIDTH:0] wbin;
   logic [ADDR_WIDTH:0] wbin_next;
   logic [ADDR_WIDTH:0] wgray_next;
   logic [ADDR_WIDTH:0] rbin_sync;
   logic [ADDR_WIDTH:0] wlevel_next;
   logic [ADDR_WIDTH:0] full_cmp;

   // Handshake: the producer may raise winc at any time.
   // A write is accepted, and the memory is written, on a rising edge where wen = winc & ~wfull is 1.
   // A winc while full is dropped and sets the sticky woverflow flag.
   assign wen        = winc & ~wfull;
   assign wbin_next  = wbin + {{ADDR_WIDTH{1'b0}}, wen};
   assign wgray_next = wbin_next ^ (wbin_next >> 1);
   assign waddr      = wbin[ADDR_WIDTH-1:0];

   // Full when the next write pointer is one lap ahead of the read pointer.
   // In Gray code, that means the top two bits are inverted and the rest are equal.
   assign full_cmp = {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]};

   always_comb begin
      rbin_sync = '0;
      for (int i = 0; i <= ADDR_WIDTH; i++) begin
         rbin_sync[i] = ^(wq2_rptr >> i);
      end
   end

   assign wlevel_next = wbin_next - rbin_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wbin         <= '0;
         wptr         <= '0;
         wfull        <= 1'b0;
         walmost_full <= 1'b0;
         wlevel       <= '0;
         woverflow    <= 1'b0;
      end else begin
         wbin         <= wbin_next;
         wptr         <= wgray_next;
         wfull        <= (wgray_next == full_cmp);
         walmost_full <= (wlevel_next >= AFULL_LVL);
         wlevel       <= wlevel_next;
         if (winc && wfull) begin
            woverflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full (ADDR_WIDTH=3, AFULL_THRESH=6).
// Uses a hand-derived vector table, a reference model feeding an expected queue, and async reset sequences.
module tb_fifo_wptr_full;

   localparam int AW = 3;
   localparam int OW = 14;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          winc = 1'b0;
   logic [AW:0]   wq2_rptr = '0;
   logic [AW:0]   wptr;
   logic [AW-1:0] waddr;
   logic          wen;
   logic          wfull;
   logic          walmost_full;
   logic [AW:0]   wlevel;
   logic          woverflow;

   fifo_wptr_full #(.ADDR_WIDTH(AW), .AFULL_THRESH(6)) dut (
      .clk(clk), .rst(rst), .winc(winc), .wq2_rptr(wq2_rptr),
      .wptr(wptr), .waddr(waddr), .wen(wen), .wfull(wfull),
      .walmost_full(walmost_full), .wlevel(wlevel), .woverflow(woverflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          winc;
      logic [AW:0]   rgray;
      logic          exp_wen;
      logic [AW:0]   exp_wptr;
      logic [AW-1:0] exp_waddr;
      logic          exp_full;
      logic          exp_afull;
      logic [AW:0]   exp_level;
      logic          exp_ovf;
   } vec_t;

   logic [OW-1:0] exp_q[$];
   int n_vec = 0;
   int n_bad = 0;

   // reference model state
   logic [AW:0] m_wbin;
   logic [AW:0] m_rbin;
   logic        m_full;
   logic        m_ovf;

   function automatic logic [OW-1:0] pack_out();
      return {wptr, waddr, wfull, walmost_full, wlevel, woverflow};
   endfunction

   function automatic logic [AW:0] b2g(input logic [AW:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [AW:0] g2b(input logic [AW:0] g);
      logic [AW:0] b;
      logic acc;
      acc = 1'b0;
      b = '0;
      for (int i = AW; i >= 0; i--) begin
         acc = acc ^ g[i];
         b[i] = acc;
      end
      return b;
   endfunction

   task automatic cmp(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b (wptr|waddr|full|afull|level|ovf)", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_wbin = '0;
      m_rbin = '0;
      m_full = 1'b0;
      m_ovf  = 1'b0;
   endtask

   // Called just after a rising edge; drives inputs, checks wen, then checks the registered outputs after the next edge.
   task automatic drive_and_check(input string name, input logic w, input logic [AW:0] rg,
                                  input logic exp_wen, input logic [OW-1:0] exp);
      winc = w;
      wq2_rptr = rg;
      #1;
      cmp({name, "_wen"}, {{(OW-1){1'b0}}, wen}, {{(OW-1){1'b0}}, exp_wen});
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s: expected queue empty", name);
      end else begin
         cmp(name, pack_out(), exp_q.pop_front());
      end
   endtask

   task automatic model_step(input string name, input logic w, input logic [AW:0] rg);
      logic          m_wen;
      logic [AW:0]   nb;
      logic [AW:0]   d;
      logic          nf;
      logic          novf;
      m_wen = w & ~m_full;
      nb    = m_wbin + {3'b000, m_wen};
      d     = nb - g2b(rg);
      nf    = (d == 4'd8);
      novf  = m_ovf | (w & m_full);
      drive_and_check(name, w, rg, m_wen, {b2g(nb), nb[AW-1:0], nf, (d >= 4'd6), d, novf});
      m_wbin = nb;
      m_full = nf;
      m_ovf  = novf;
   endtask

   task automatic async_reset_pulse(input string name);
      #2 rst = 1'b1;
      #1 cmp({name, "_during"}, {pack_out()}, '0);
      rst = 1'b0;
      #1 cmp({name, "_after"}, {pack_out()}, '0);
      model_reset();
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[11];

   initial begin
      // fill 8, overflow attempt, idle at full, drain release
      vecs[0]  = '{1'b1, 4'b0000, 1'b1, 4'b0001, 3'd1, 1'b0, 1'b0, 4'd1, 1'b0};
      vecs[1]  = '{1'b1, 4'b0000, 1'b1, 4'b0011, 3'd2, 1'b0, 1'b0, 4'd2, 1'b0};
      vecs[2]  = '{1'b1, 4'b0000, 1'b1, 4'b0010, 3'd3, 1'b0, 1'b0, 4'd3, 1'b0};
      vecs[3]  = '{1'b1, 4'b0000, 1'b1, 4'b0110, 3'd4, 1'b0, 1'b0, 4'd4, 1'b0};
      vecs[4]  = '{1'b1, 4'b0000, 1'b1, 4'b0111, 3'd5, 1'b0, 1'b0, 4'd5, 1'b0};
      vecs[5]  = '{1'b1, 4'b0000, 1'b1, 4'b0101, 3'd6, 1'b0, 1'b1, 4'd6, 1'b0};
      vecs[6]  = '{1'b1, 4'b0000, 1'b1, 4'b0100, 3'd7, 1'b0, 1'b1, 4'd7, 1'b0};
      vecs[7]  = '{1'b1, 4'b0000, 1'b1, 4'b1100, 3'd0, 1'b1, 1'b1, 4'd8, 1'b0};
      vecs[8]  = '{1'b1, 4'b0000, 1'b0, 4'b1100, 3'd0, 1'b1, 1'b1, 4'd8, 1'b1};
      vecs[9]  = '{1'b0, 4'b0000, 1'b0, 4'b1100, 3'd0, 1'b1, 1'b1, 4'd8, 1'b1};
      vecs[10] = '{1'b0, 4'b0001, 1'b0, 4'b1100, 3'd0, 1'b0, 1'b1, 4'd7, 1'b1};

      model_reset();
      #3;
      cmp("reset_state", pack_out(), '0);
      cmp("reset_wen", {{(OW-1){1'b0}}, wen}, '0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 11; i++) begin
         drive_and_check($sformatf("vec%0d", i), vecs[i].winc, vecs[i].rgray, vecs[i].exp_wen,
                         {vecs[i].exp_wptr, vecs[i].exp_waddr, vecs[i].exp_full,
                          vecs[i].exp_afull, vecs[i].exp_level, vecs[i].exp_ovf});
      end

      // sticky overflow cleared only by reset
      winc = 1'b0;
      wq2_rptr = '0;
      async_reset_pulse("rst_clear_ovf");

      // write up to wbin=5, then reset between edges
      for (int i = 0; i < 5; i++) model_step($sformatf("pre_rst_wr%0d", i), 1'b1, 4'b0000);
      cmp("wbin5_wptr", {10'd0, wptr}, {10'd0, 4'b0111});
      winc = 1'b0;
      async_reset_pulse("rst_mid");
      model_step("post_rst_wr", 1'b1, 4'b0000);
      cmp("post_rst_wptr_waddr", {7'd0, wptr, waddr}, {7'd0, 4'b0001, 3'b001});

      // wrap: read pointer trails by one so level stays 2 across 1111->0000
      for (int i = 0; i < 20; i++) begin
         model_step($sformatf("wrap%0d", i), 1'b1, b2g(m_wbin - 4'd1));
      end

      // random traffic: reads advance but never pass committed writes
      m_rbin = m_wbin - 4'd1;
      for (int i = 0; i < 60; i++) begin
         if (m_rbin != m_wbin && $urandom_range(0, 2) == 0) m_rbin = m_rbin + 4'd1;
         model_step($sformatf("rand%0d", i), 1'($urandom_range(0, 3) != 0), b2g(m_rbin));
      end

      // full then simultaneous read advance with a write attempt
      for (int i = 0; i < 10; i++) model_step($sformatf("refill%0d", i), 1'b1, b2g(m_rbin));
      m_rbin = m_rbin + 4'd1;
      model_step("simul_adv_winc", 1'b1, b2g(m_rbin));
      model_step("simul_after", 1'b1, b2g(m_rbin));

      if (exp_q.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL leftover_expected: got %0d entries, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
